// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared types and constants for the branch target buffer
package isa_pkg;

  // 2-bit branch direction counter; bit 1 set means predict taken
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } pred_state_t;

  // Default direct-mapped table depth
  localparam int BTB_NUM_ENTRIES_DEFAULT = 16;

  // Word-aligned PCs: the low two bits never reach index or tag
  localparam int PC_W      = 32;
  localparam int PC_WORD_W = PC_W - 2;

  // True when a counter state predicts taken
  function automatic logic pred_taken(input pred_state_t s);
    return s[1];
  endfunction

endpackage

// File: rtl/btb_if.sv
// rtl/btb_if.sv - fetch lookup and branch-unit update bundle for the BTB
interface btb_if;
  import isa_pkg::*;

  // Fetch-side lookup
  logic [PC_W-1:0] fetch_pc;
  logic            btb_hit;
  logic            predicted_outcome;
  logic [PC_W-1:0] predicted_pc;

  // Branch-unit update and table maintenance
  logic            flush;
  logic            update_btb;
  logic [PC_W-1:0] update_pc;
  logic [PC_W-1:0] branch_target;
  logic            branch_outcome;

  // Requester side: drives PCs and updates, receives predictions
  modport master (
    output fetch_pc,
    output flush,
    output update_btb,
    output update_pc,
    output branch_target,
    output branch_outcome,
    input  btb_hit,
    input  predicted_outcome,
    input  predicted_pc
  );

  // Table side: consumes PCs and updates, produces predictions
  modport slave (
    input  fetch_pc,
    input  flush,
    input  update_btb,
    input  update_pc,
    input  branch_target,
    input  branch_outcome,
    output btb_hit,
    output predicted_outcome,
    output predicted_pc
  );

endinterface

// File: rtl/btb_core.sv
// rtl/btb_core.sv - direct-mapped flop table with combinational lookup
module btb_core
  import isa_pkg::*;
#(
  parameter int NUM_ENTRIES = BTB_NUM_ENTRIES_DEFAULT
) (
  input  logic    CLK,
  input  logic    nRST,
  btb_if.slave    bus
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int TAG_W = PC_WORD_W - IDX_W;

  // Table storage
  logic              r_valid  [NUM_ENTRIES];
  logic [TAG_W-1:0]  r_tag    [NUM_ENTRIES];
  logic [PC_W-1:0]   r_target [NUM_ENTRIES];
  pred_state_t       r_ctr    [NUM_ENTRIES];

  // Lookup path
  logic [IDX_W-1:0]  w_f_idx;
  logic [TAG_W-1:0]  w_f_tag;
  logic              w_f_hit;
  pred_state_t       w_f_ctr;
  logic              w_f_taken;
  logic [PC_W-1:0]   w_f_seq_pc;

  // Update path
  logic [IDX_W-1:0]  w_u_idx;
  logic [TAG_W-1:0]  w_u_tag;
  logic              w_u_hit;
  pred_state_t       w_u_ctr;
  pred_state_t       w_u_ctr_next;

  // Instruction PCs are word aligned; the low bits carry no information
  logic              w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^{bus.fetch_pc[1:0], bus.update_pc[1:0]};

  assign w_f_idx    = bus.fetch_pc[IDX_W+1:2];
  assign w_f_tag    = bus.fetch_pc[PC_W-1:IDX_W+2];
  assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_f_ctr    = r_ctr[w_f_idx];
  assign w_f_taken  = w_f_hit && pred_taken(w_f_ctr);
  // Wraps naturally at 2^32
  assign w_f_seq_pc = bus.fetch_pc + 32'd4;

  // Lookup reads the registered table only, so a same-cycle update is not bypassed
  assign bus.btb_hit           = w_f_hit;
  assign bus.predicted_outcome = w_f_taken;
  assign bus.predicted_pc      = w_f_taken ? r_target[w_f_idx] : w_f_seq_pc;

  assign w_u_idx = bus.update_pc[IDX_W+1:2];
  assign w_u_tag = bus.update_pc[PC_W-1:IDX_W+2];
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_u_ctr = r_ctr[w_u_idx];

  sat_counter2 u_sat_counter2 (
    .state      (w_u_ctr),
    .taken      (bus.branch_outcome),
    .next_state (w_u_ctr_next)
  );

  // Sole writer of the table: reset, flush (wins over update), then hit-train or miss-allocate
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= WNT;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (bus.update_btb) begin
      if (w_u_hit) begin
        r_ctr[w_u_idx] <= w_u_ctr_next;
        if (bus.branch_outcome) begin
          r_target[w_u_idx] <= bus.branch_target;
        end
      end else if (bus.branch_outcome) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= bus.branch_target;
        r_ctr[w_u_idx]    <= WT;
      end
    end
  end

endmodule

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating direction counter next-state
module sat_counter2
  import isa_pkg::*;
(
  input  pred_state_t state,
  input  logic        taken,
  output pred_state_t next_state
);

  // Step toward ST on taken, toward SNT on not-taken, holding at the ends
  always_comb begin
    next_state = state;
    case (state)
      SNT:     next_state = taken ? WNT : SNT;
      WNT:     next_state = taken ? WT  : SNT;
      WT:      next_state = taken ? ST  : WNT;
      ST:      next_state = taken ? ST  : WT;
      default: next_state = state;
    endcase
  end

endmodule

// File: rtl/btb.sv
// rtl/btb.sv - branch target buffer top: flat ports onto the internal bundle
module btb
  import isa_pkg::*;
#(
  parameter int NUM_ENTRIES = BTB_NUM_ENTRIES_DEFAULT
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic            flush,
  input  logic            update_btb,
  input  logic [PC_W-1:0] update_pc,
  input  logic [PC_W-1:0] branch_target,
  input  logic            branch_outcome,
  output logic            btb_hit,
  output logic            predicted_outcome,
  output logic [PC_W-1:0] predicted_pc
);

  btb_if w_bus ();

  assign w_bus.fetch_pc       = fetch_pc;
  assign w_bus.flush          = flush;
  assign w_bus.update_btb     = update_btb;
  assign w_bus.update_pc      = update_pc;
  assign w_bus.branch_target  = branch_target;
  assign w_bus.branch_outcome = branch_outcome;

  assign btb_hit           = w_bus.btb_hit;
  assign predicted_outcome = w_bus.predicted_outcome;
  assign predicted_pc      = w_bus.predicted_pc;

  btb_core #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_btb_core (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (w_bus)
  );

endmodule

// File: doc/btb.md
BTB -- requirements
Module: btb

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16, giving the direct-mapped entry count; power of two, 2..256.
REQ-002 SHALL derive IDX_W = log2(NUM_ENTRIES) and TAG_W = 30 - IDX_W internally; neither is a parameter.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fetch_pc  input  32  PC being fetched; bits [1:0] ignored.
REQ-006 SHALL have port flush  input  1  synchronous invalidate-all request.
REQ-007 SHALL have port update_btb  input  1  one-cycle update strobe from the branch unit.
REQ-008 SHALL have port update_pc  input  32  PC of the resolved branch.
REQ-009 SHALL have port branch_target  input  32  computed taken target of the resolved branch.
REQ-010 SHALL have port branch_outcome  input  1  resolved direction; 1 = taken.
REQ-011 SHALL have port btb_hit  output  1  fetch_pc matches a valid entry.
REQ-012 SHALL have port predicted_outcome  output  1  predicted direction; feeds the branch unit's predicted_outcome.
REQ-013 SHALL have port predicted_pc  output  32  next fetch PC.

Function
REQ-014 SHALL compute index = pc[IDX_W+1:2] and tag = pc[31:IDX_W+2] for both the lookup and update paths.
REQ-015 Each entry SHALL hold: valid bit, TAG_W-bit tag, 32-bit target, and a 2-bit counter with states SNT=0, WNT=1, WT=2, ST=3.
REQ-016 Lookup SHALL be combinational, with zero latency: btb_hit = valid[idx] && tag match; predicted_outcome = btb_hit && counter[1].
REQ-017 predicted_pc SHALL equal the entry target when predicted_outcome=1, else fetch_pc+4 (modulo 2^32: 0xFFFFFFFC -> 0x00000000).
REQ-018 Update on a hit (update_btb=1, valid, tag match) SHALL behave as follows:
- Counter saturating increment if taken, decrement if not taken; ST+taken stays ST, SNT+not-taken stays SNT.
- Target overwritten with branch_target only when taken.
REQ-019 Update on a miss with branch_outcome=1 SHALL allocate the entry: valid=1, new tag, target=branch_target, counter=WT; any previous occupant is replaced.
REQ-020 Update on a miss with branch_outcome=0 SHALL leave the table unchanged.
REQ-021 update_btb=0 SHALL leave the table unchanged regardless of the other update inputs.
REQ-022 flush=1 SHALL clear every valid bit at the next edge; tags, targets and counters may retain stale values.
REQ-023 flush and update_btb asserted in the same cycle: flush SHALL win and no allocation survives.
REQ-024 Lookup and update to the same index in the same cycle: lookup SHALL return the pre-update contents (no bypass); the new value is visible from the next cycle.
REQ-025 Back-to-back updates on consecutive cycles to the same index SHALL each apply to the result of the previous one.

Reset
REQ-026 nRST=0 SHALL asynchronously clear all valid bits and set all counters to WNT; tags and targets need no reset.
REQ-027 During and immediately after reset, outputs SHALL be: btb_hit=0, predicted_outcome=0, predicted_pc=fetch_pc+4.
REQ-028 Reset asserted mid-update SHALL discard that update; the table is empty on reset release.

Structure
REQ-029 The 2-bit counter enum (pred_state_t: SNT, WNT, WT, ST) and the NUM_ENTRIES default constant SHALL live in isa_pkg.
REQ-030 Counter next-state logic SHALL be one sub-module, sat_counter2, with inputs state and taken and output next_state; it is instantiated once on the update path.
REQ-031 Storage SHALL use flops (no SRAM macro); the table is written only in a single always_ff.

Verification
REQ-032 Reset, then fetch_pc=0x100 -> btb_hit=0, predicted_outcome=0, predicted_pc=0x104.
REQ-033 Update update_pc=0x100, target=0x200, taken; next cycle fetch_pc=0x100 -> btb_hit=1, predicted_outcome=1, predicted_pc=0x200.
REQ-034 Same entry, two not-taken updates -> counter WT->WNT->SNT; fetch 0x100 gives predicted_outcome=0, predicted_pc=0x104; a third not-taken update keeps SNT.
REQ-035 NUM_ENTRIES=16: allocate 0x100 (taken), then taken update to 0x140 (same index, different tag):
- fetch 0x100 -> btb_hit=0.
- fetch 0x140 -> btb_hit=1, counter WT.
REQ-036 Simultaneous flush=1 and taken update_btb for 0x300 -> next cycle fetch 0x300 and 0x100 both give btb_hit=0.
REQ-037 fetch_pc=0xFFFFFFFC on a miss -> predicted_pc=0x00000000; assert nRST while update_btb=1 -> no entry valid after release.
